// File: rtl/ps2_command_scheduler_pkg.sv
// Shared definitions for the PS/2 command scheduler: decode FSM states and
// the scan-code constants the decoder reacts to.
package ps2_command_scheduler_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BREAK = 2'd1,
        ST_EXT   = 2'd2
    } state_t;

    localparam logic [7:0] SCAN_F0    = 8'hF0;
    localparam logic [7:0] SCAN_E0    = 8'hE0;
    localparam logic [7:0] ENTER_CODE = 8'h5A;
    localparam logic [7:0] BKSP_CODE  = 8'h66;

    localparam int CMD_WIDTH = 32;

endpackage

// File: rtl/ps2_command_scheduler_if.sv
// Key-input and command-output handshake bundle of the scheduler.
// The slave side is the scheduler; the master side is keyboard plus processor.
interface ps2_command_scheduler_if;
    import ps2_command_scheduler_pkg::*;

    logic                 key_valid;
    logic [7:0]           key_scan;
    logic                 cmd_valid;
    logic                 cmd_ready;
    logic [CMD_WIDTH-1:0] cmd_data;

    modport slave (
        input  key_valid,
        input  key_scan,
        input  cmd_ready,
        output cmd_valid,
        output cmd_data
    );

    modport master (
        output key_valid,
        output key_scan,
        output cmd_ready,
        input  cmd_valid,
        input  cmd_data
    );

endinterface

// File: rtl/ps2_command_scheduler_cmd_fifo.sv
// Show-ahead command FIFO. A push while full is only taken when a pop frees
// a slot on the same edge; valid is registered from the next-state count.
module cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             valid,
    output logic [3:0]       count,
    output logic             full
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic             do_push;
    logic             do_pop;
    logic [3:0]       count_next;

    assign full    = (count == 4'(DEPTH));
    assign do_pop  = pop && valid;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    always_comb begin
        count_next = count;
        if (do_push && !do_pop) begin
            count_next = count + 4'd1;
        end else if (do_pop && !do_push) begin
            count_next = count - 4'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= 4'd0;
            valid  <= 1'b0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count_next;
            valid <= (count_next != 4'd0);
        end
    end

endmodule

// File: rtl/ps2_command_scheduler_scan_map.sv
// Combinational PS/2 set-2 scan code to ASCII map for letters and digits;
// anything else maps to 8'h00.
module ps2_scan_to_ascii (
    input  logic [7:0] scan,
    output logic [7:0] ascii
);

    always_comb begin
        ascii = 8'h00;
        case (scan)
            8'h1C: ascii = 8'h41;
            8'h32: ascii = 8'h42;
            8'h21: ascii = 8'h43;
            8'h23: ascii = 8'h44;
            8'h24: ascii = 8'h45;
            8'h2B: ascii = 8'h46;
            8'h34: ascii = 8'h47;
            8'h33: ascii = 8'h48;
            8'h43: ascii = 8'h49;
            8'h3B: ascii = 8'h4A;
            8'h42: ascii = 8'h4B;
            8'h4B: ascii = 8'h4C;
            8'h3A: ascii = 8'h4D;
            8'h31: ascii = 8'h4E;
            8'h44: ascii = 8'h4F;
            8'h4D: ascii = 8'h50;
            8'h15: ascii = 8'h51;
            8'h2D: ascii = 8'h52;
            8'h1B: ascii = 8'h53;
            8'h2C: ascii = 8'h54;
            8'h3C: ascii = 8'h55;
            8'h2A: ascii = 8'h56;
            8'h1D: ascii = 8'h57;
            8'h22: ascii = 8'h58;
            8'h35: ascii = 8'h59;
            8'h1A: ascii = 8'h5A;
            8'h45: ascii = 8'h30;
            8'h16: ascii = 8'h31;
            8'h1E: ascii = 8'h32;
            8'h26: ascii = 8'h33;
            8'h25: ascii = 8'h34;
            8'h2E: ascii = 8'h35;
            8'h36: ascii = 8'h36;
            8'h3D: ascii = 8'h37;
            8'h3E: ascii = 8'h38;
            8'h46: ascii = 8'h39;
            default: ascii = 8'h00;
        endcase
    end

endmodule

// File: rtl/ps2_command_scheduler.sv
// Assembles PS/2 keystrokes into up-to-four-character command words and
// queues finished words for a processor through a show-ahead FIFO.
module ps2_command_scheduler
    import ps2_command_scheduler_pkg::*;
#(
    parameter int         DEPTH      = 4,
    parameter logic [7:0] ENTER_CODE = ps2_command_scheduler_pkg::ENTER_CODE,
    parameter logic [7:0] BKSP_CODE  = ps2_command_scheduler_pkg::BKSP_CODE
) (
    input  logic                   clock,
    input  logic                   resetn,
    ps2_command_scheduler_if.slave bus,
    output logic                   echo_valid,
    output logic [7:0]             echo_char,
    output logic [2:0]             char_count,
    output logic [3:0]             fifo_count,
    output logic                   overflow
);

    state_t               state;
    logic [CMD_WIDTH-1:0] word;
    logic [7:0]           ascii;
    logic                 idle_key;
    logic                 enter_key;
    logic                 bksp_key;
    logic                 accept_char;
    logic                 push;
    logic [CMD_WIDTH-1:0] push_word;
    logic [CMD_WIDTH-1:0] shifted_word;
    logic                 fifo_valid;
    logic                 fifo_full;
    logic                 pop;

    ps2_scan_to_ascii u_map (
        .scan  (bus.key_scan),
        .ascii (ascii)
    );

    // Enter and backspace take priority over the character map and are
    // no-ops on an empty partial word.
    always_comb begin
        idle_key     = bus.key_valid && (state == ST_IDLE) &&
                       (bus.key_scan != SCAN_F0) && (bus.key_scan != SCAN_E0);
        enter_key    = idle_key && (bus.key_scan == ENTER_CODE) && (char_count != 3'd0);
        bksp_key     = idle_key && (bus.key_scan == BKSP_CODE) && (char_count != 3'd0);
        accept_char  = idle_key && (bus.key_scan != ENTER_CODE) &&
                       (bus.key_scan != BKSP_CODE) && (ascii != 8'h00);
        shifted_word = {word[23:0], ascii};
        push         = enter_key || (accept_char && (char_count == 3'd3));
        push_word    = enter_key ? word : shifted_word;
    end

    assign pop = fifo_valid && bus.cmd_ready;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state      <= ST_IDLE;
            word       <= '0;
            char_count <= 3'd0;
            echo_valid <= 1'b0;
            echo_char  <= 8'h00;
        end else begin
            echo_valid <= 1'b0;
            if (bus.key_valid) begin
                case (state)
                    ST_IDLE: begin
                        if (bus.key_scan == SCAN_F0) begin
                            state <= ST_BREAK;
                        end else if (bus.key_scan == SCAN_E0) begin
                            state <= ST_EXT;
                        end
                    end
                    ST_BREAK: state <= ST_IDLE;
                    ST_EXT:   state <= (bus.key_scan == SCAN_F0) ? ST_BREAK : ST_IDLE;
                    default:  state <= ST_IDLE;
                endcase
            end
            if (push) begin
                word       <= '0;
                char_count <= 3'd0;
            end else if (accept_char) begin
                word       <= shifted_word;
                char_count <= char_count + 3'd1;
            end else if (bksp_key) begin
                word       <= word >> 8;
                char_count <= char_count - 3'd1;
            end
            if (accept_char) begin
                echo_valid <= 1'b1;
                echo_char  <= ascii;
            end
        end
    end

    // A full FIFO without a same-edge pop drops the word and latches overflow.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            overflow <= 1'b0;
        end else if (push && fifo_full && !pop) begin
            overflow <= 1'b1;
        end
    end

    cmd_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (CMD_WIDTH)
    ) u_fifo (
        .clock     (clock),
        .resetn    (resetn),
        .push      (push),
        .push_data (push_word),
        .pop       (bus.cmd_ready),
        .head      (bus.cmd_data),
        .valid     (fifo_valid),
        .count     (fifo_count),
        .full      (fifo_full)
    );

    assign bus.cmd_valid = fifo_valid;

endmodule

// File: tb/tb_ps2_command_scheduler.sv
// Directed bench for ps2_command_scheduler with hand-computed expectations.
module tb_ps2_command_scheduler;

    logic       clock;
    logic       resetn;
    logic       echo_valid;
    logic [7:0] echo_char;
    logic [2:0] char_count;
    logic [3:0] fifo_count;
    logic       overflow;

    int vectors;
    int miscompares;

    ps2_command_scheduler_if bus ();

    ps2_command_scheduler #(
        .DEPTH (4)
    ) dut (
        .clock      (clock),
        .resetn     (resetn),
        .bus        (bus),
        .echo_valid (echo_valid),
        .echo_char  (echo_char),
        .char_count (char_count),
        .fifo_count (fifo_count),
        .overflow   (overflow)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
        end
    endtask

    // Key strobe is one cycle wide; outputs are observed at the next falling edge.
    task automatic apply_key(input logic [7:0] code, input logic ready);
        @(negedge clock);
        bus.key_valid = 1'b1;
        bus.key_scan  = code;
        bus.cmd_ready = ready;
        @(negedge clock);
        bus.key_valid = 1'b0;
        bus.cmd_ready = 1'b0;
    endtask

    task automatic apply_word(input logic [31:0] codes);
        apply_key(codes[31:24], 1'b0);
        apply_key(codes[23:16], 1'b0);
        apply_key(codes[15:8], 1'b0);
        apply_key(codes[7:0], 1'b0);
    endtask

    task automatic pop_one();
        @(negedge clock);
        bus.cmd_ready = 1'b1;
        @(negedge clock);
        bus.cmd_ready = 1'b0;
    endtask

    task automatic drain_check(input string tag, input logic [31:0] w0, input logic [31:0] w1,
                               input logic [31:0] w2, input logic [31:0] w3);
        logic [31:0] exp_w [4];
        exp_w = '{w0, w1, w2, w3};
        @(negedge clock);
        bus.cmd_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check({tag, "_valid"}, {31'd0, bus.cmd_valid}, 32'd1);
            check({tag, "_data"}, bus.cmd_data, exp_w[i]);
            @(negedge clock);
        end
        bus.cmd_ready = 1'b0;
        check({tag, "_empty_valid"}, {31'd0, bus.cmd_valid}, 32'd0);
        check({tag, "_empty_count"}, {28'd0, fifo_count}, 32'd0);
    endtask

    initial begin
        vectors       = 0;
        miscompares   = 0;
        bus.key_valid = 1'b0;
        bus.key_scan  = 8'h00;
        bus.cmd_ready = 1'b0;
        resetn        = 1'b0;
        repeat (3) @(negedge clock);

        check("rst_cmd_valid", {31'd0, bus.cmd_valid}, 32'd0);
        check("rst_fifo_count", {28'd0, fifo_count}, 32'd0);
        check("rst_char_count", {29'd0, char_count}, 32'd0);
        check("rst_overflow", {31'd0, overflow}, 32'd0);
        check("rst_echo_valid", {31'd0, echo_valid}, 32'd0);
        resetn = 1'b1;

        // "FD10": four characters auto-push on the fourth key.
        $display("[TB] four-character word");
        apply_key(8'h2B, 1'b0);
        check("w1_echo1_v", {31'd0, echo_valid}, 32'd1);
        check("w1_echo1_c", {24'd0, echo_char}, 32'h46);
        check("w1_count1", {29'd0, char_count}, 32'd1);
        apply_key(8'h23, 1'b0);
        check("w1_echo2_c", {24'd0, echo_char}, 32'h44);
        check("w1_count2", {29'd0, char_count}, 32'd2);
        apply_key(8'h16, 1'b0);
        check("w1_echo3_c", {24'd0, echo_char}, 32'h31);
        check("w1_count3", {29'd0, char_count}, 32'd3);
        check("w1_not_yet_valid", {31'd0, bus.cmd_valid}, 32'd0);
        apply_key(8'h45, 1'b0);
        check("w1_echo4_v", {31'd0, echo_valid}, 32'd1);
        check("w1_echo4_c", {24'd0, echo_char}, 32'h30);
        check("w1_count0", {29'd0, char_count}, 32'd0);
        check("w1_cmd_valid", {31'd0, bus.cmd_valid}, 32'd1);
        check("w1_cmd_data", bus.cmd_data, 32'h46443130);
        check("w1_fifo_count", {28'd0, fifo_count}, 32'd1);
        @(negedge clock);
        check("w1_echo_pulse_end", {31'd0, echo_valid}, 32'd0);
        check("w1_hold_data", bus.cmd_data, 32'h46443130);
        pop_one();
        check("w1_popped_valid", {31'd0, bus.cmd_valid}, 32'd0);
        check("w1_popped_count", {28'd0, fifo_count}, 32'd0);

        // Break and extended prefixes must be swallowed without echo.
        $display("[TB] break and extended codes");
        apply_key(8'h1C, 1'b0);
        check("brk_echo_a", {24'd0, echo_char}, 32'h41);
        apply_key(8'hF0, 1'b0);
        check("brk_f0_echo", {31'd0, echo_valid}, 32'd0);
        apply_key(8'h1C, 1'b0);
        check("brk_release_echo", {31'd0, echo_valid}, 32'd0);
        check("brk_release_count", {29'd0, char_count}, 32'd1);
        apply_key(8'hE0, 1'b0);
        check("ext_e0_echo", {31'd0, echo_valid}, 32'd0);
        apply_key(8'hF0, 1'b0);
        apply_key(8'h75, 1'b0);
        check("ext_75_echo", {31'd0, echo_valid}, 32'd0);
        check("ext_75_count", {29'd0, char_count}, 32'd1);
        apply_key(8'h5A, 1'b0);
        check("enter_count", {29'd0, char_count}, 32'd0);
        check("enter_fifo_count", {28'd0, fifo_count}, 32'd1);
        check("enter_data", bus.cmd_data, 32'h00000041);
        check("enter_echo", {31'd0, echo_valid}, 32'd0);
        pop_one();

        // Backspace trims the newest character.
        $display("[TB] backspace");
        apply_key(8'h32, 1'b0);
        check("bk_count1", {29'd0, char_count}, 32'd1);
        apply_key(8'h21, 1'b0);
        check("bk_count2", {29'd0, char_count}, 32'd2);
        apply_key(8'h66, 1'b0);
        check("bk_count3", {29'd0, char_count}, 32'd1);
        apply_key(8'h23, 1'b0);
        check("bk_count4", {29'd0, char_count}, 32'd2);
        apply_key(8'h5A, 1'b0);
        check("bk_count5", {29'd0, char_count}, 32'd0);
        check("bk_data", bus.cmd_data, 32'h00004244);
        pop_one();
        apply_key(8'h66, 1'b0);
        check("bk_empty_count", {29'd0, char_count}, 32'd0);
        check("bk_empty_echo", {31'd0, echo_valid}, 32'd0);
        apply_key(8'h5A, 1'b0);
        check("enter_empty_fifo", {28'd0, fifo_count}, 32'd0);
        check("enter_empty_valid", {31'd0, bus.cmd_valid}, 32'd0);

        // Five words into a four-deep FIFO: the fifth is dropped.
        $display("[TB] overflow");
        apply_word(32'h1C322123);
        apply_word(32'h161E2625);
        apply_word(32'h1D22351A);
        apply_word(32'h2E363D3E);
        check("ovf_full_count", {28'd0, fifo_count}, 32'd4);
        check("ovf_before", {31'd0, overflow}, 32'd0);
        apply_word(32'h46451C32);
        check("ovf_count", {28'd0, fifo_count}, 32'd4);
        check("ovf_flag", {31'd0, overflow}, 32'd1);
        check("ovf_head", bus.cmd_data, 32'h41424344);
        check("ovf_char_count", {29'd0, char_count}, 32'd0);
        drain_check("ovf_drain", 32'h41424344, 32'h31323334, 32'h5758595A, 32'h35363738);
        @(negedge clock);
        bus.cmd_ready = 1'b1;
        repeat (2) @(negedge clock);
        bus.cmd_ready = 1'b0;
        check("empty_ready_count", {28'd0, fifo_count}, 32'd0);
        check("empty_ready_valid", {31'd0, bus.cmd_valid}, 32'd0);
        check("ovf_sticky", {31'd0, overflow}, 32'd1);

        // Reset mid-word with queued words discards everything immediately.
        $display("[TB] reset with pending data");
        apply_word(32'h1C322123);
        apply_word(32'h161E2625);
        apply_key(8'h1C, 1'b0);
        apply_key(8'h32, 1'b0);
        check("pre_rst_char_count", {29'd0, char_count}, 32'd2);
        check("pre_rst_fifo_count", {28'd0, fifo_count}, 32'd2);
        #2;
        resetn = 1'b0;
        #1;
        check("async_rst_valid", {31'd0, bus.cmd_valid}, 32'd0);
        check("async_rst_char_count", {29'd0, char_count}, 32'd0);
        check("async_rst_fifo_count", {28'd0, fifo_count}, 32'd0);
        check("async_rst_overflow", {31'd0, overflow}, 32'd0);
        @(negedge clock);
        resetn = 1'b1;
        apply_word(32'h2B231645);
        check("post_rst_data", bus.cmd_data, 32'h46443130);
        check("post_rst_count", {28'd0, fifo_count}, 32'd1);
        pop_one();

        // Full FIFO, fourth character lands on the same edge as a pop.
        $display("[TB] push and pop while full");
        apply_word(32'h1C322123);
        apply_word(32'h161E2625);
        apply_word(32'h1D22351A);
        apply_word(32'h2E363D3E);
        apply_key(8'h46, 1'b0);
        apply_key(8'h45, 1'b0);
        apply_key(8'h1C, 1'b0);
        apply_key(8'h32, 1'b1);
        check("pp_count", {28'd0, fifo_count}, 32'd4);
        check("pp_overflow", {31'd0, overflow}, 32'd0);
        check("pp_head", bus.cmd_data, 32'h31323334);
        drain_check("pp_drain", 32'h31323334, 32'h5758595A, 32'h35363738, 32'h39304142);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
